// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM-stage load/store port.
// One request at a time: accept in IDLE, optional wait states, then a one-cycle
// response. Writes and reads commit on the edge that enters RESP.
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic [1:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic                  addr_err_q;

    logic [31:0] mem [DEPTH];

    logic                  req_err;
    logic                  accept;
    logic                  commit;
    logic                  c_we;
    logic [3:0]            c_be;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [31:0]           c_wdata;
    logic                  c_err;
    logic                  unused_addr_hi;

    // Upper address bits alias onto the array.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    // Lane-enable / address-offset legality check on the live request.
    always_comb begin
        req_err = 1'b1;
        case (req_be)
            4'b1111, 4'b0011: req_err = (req_addr[1:0] != 2'd0);
            4'b1100:          req_err = (req_addr[1:0] != 2'd2);
            4'b0001:          req_err = (req_addr[1:0] != 2'd0);
            4'b0010:          req_err = (req_addr[1:0] != 2'd1);
            4'b0100:          req_err = (req_addr[1:0] != 2'd2);
            4'b1000:          req_err = (req_addr[1:0] != 2'd3);
            default:          req_err = 1'b1;
        endcase
    end

    assign accept     = (state_q == ST_IDLE) && req_valid && !rst;
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign addr_err   = addr_err_q;

    // With zero wait states the commit happens on the accept edge, so it must use the
    // live request rather than the latched copy.
    always_comb begin
        commit = ((state_q == ST_WAIT) && (cnt_q == 3'd0) && !rst) ||
                 (accept && (WAIT_CYCLES == 0));
        if (state_q == ST_IDLE) begin
            c_we    = req_we;
            c_be    = req_be;
            c_idx   = req_addr[ADDR_WIDTH+1:2];
            c_wdata = req_wdata;
            c_err   = req_err;
        end else begin
            c_we    = we_q;
            c_be    = be_q;
            c_idx   = idx_q;
            c_wdata = wdata_q;
            c_err   = err_q;
        end
    end

    // Next-state and wait-count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, request latch and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                be_q    <= req_be;
                idx_q   <= req_addr[ADDR_WIDTH+1:2];
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (commit) begin
                addr_err_q <= c_err;
                rdata_q    <= c_err ? 32'd0 : mem[c_idx];
            end
        end
    end

    // Byte-lane store into the array; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder serving the MEM-stage load/store port of the pipelined MIPS datapath. It accepts one word-addressed request at a time with byte-lane enables, inserts a programmable number of wait states, and commits writes or returns read words. While a request is pending it drives a stall request to the hazard unit. Read data is returned as a full word; byte and halfword extraction stays in the datapath's load-select logic.

## Interface
- ADDR_WIDTH, 10, word-index bits; depth = 2^ADDR_WIDTH 32-bit words
- WAIT_CYCLES, 2, wait states between accept and response; legal range 0..7

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM stage presents an access
- req_we  in  1  1 = store, 0 = load
- req_be  in  4  byte-lane enables; bit i = byte lane i, bits [7+8i:8i]
- req_addr  in  32  byte address (alu_out_M)
- req_wdata  in  32  lane-aligned store data (write_data_M)
- req_ready  out  1  request accepted this cycle
- busy  out  1  stall request to hazard unit
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read word; valid only with resp_valid
- addr_err  out  1  alignment error flag; valid only with resp_valid

## Operation
- Storage: 2^ADDR_WIDTH x 32 array, indexed by req_addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses alias (wrap). Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1.
    - On req_valid, latch we, be, addr, wdata and the error check result.
    - Next state is WAIT (count loaded with WAIT_CYCLES-1) if WAIT_CYCLES > 0, else RESP.
  - WAIT: decrement the count. At count 0, go to RESP.
  - RESP: resp_valid = 1, then go to IDLE unconditionally. Requests are not accepted in WAIT or RESP.
- Alignment check, using the latched addr[1:0]:
  - be 1111 requires 00.
  - be 0011 requires 00.
  - be 1100 requires 10.
  - One-hot be requires the set bit index to equal addr[1:0].
  - Any other pattern, including 0000, is an error.
- Commit, on the clock edge that enters RESP:
  - No error and we = 1: write the enabled lanes only; disabled lanes are unchanged.
  - No error and we = 0: resp_rdata = array word.
  - Error: no array write, resp_rdata = 0, addr_err = 1.
- A read issued after a completed write to the same word returns the new data.
- busy = (IDLE & req_valid) | WAIT. busy is 0 in RESP, so the pipeline advances on the edge that ends RESP.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, count 0
  - resp_valid 0, resp_rdata 0, addr_err 0
  - req_ready 1; busy follows req_valid
- Latency: accept at edge t gives resp_valid high during cycle t+WAIT_CYCLES+1, for exactly one cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles; a one-cycle gap in IDLE follows every RESP.
- resp_rdata and addr_err hold their values after RESP until the next commit. They are meaningful only while resp_valid = 1.
- Request inputs are sampled only at accept; later changes are ignored.
- Reset during WAIT or RESP:
  - A pending write is discarded; the array is unchanged.
  - No resp_valid is issued.
  - After reset deasserts, the FSM is in IDLE.
- Simultaneous reset and req_valid: reset wins and no request is accepted.

## Test plan
- Aligned word store/load, WAIT_CYCLES = 2:
  - Write 0xDEADBEEF, be 1111, addr 0x10, accepted at t -> resp_valid at t+3, addr_err 0.
  - Read 0x10 -> resp_rdata 0xDEADBEEF.
- Byte store: be 0100, addr 0x12, wdata 0x00AB0000 over 0xDEADBEEF -> read 0x10 returns 0xDEABBEEF.
- Misaligned: be 1111, addr 0x11, write 0x12345678 -> resp_valid with addr_err 1, resp_rdata 0; read 0x10 still returns 0xDEABBEEF.
- WAIT_CYCLES = 0: accept at t -> resp_valid at t+1; busy high only in the accept cycle. Back-to-back req_valid gets req_ready 0 in RESP and is accepted in the following IDLE.
- Reset mid-write: store 0xCAFEF00D to 0x20 (prior value 0x11111111), assert rst during WAIT -> no resp_valid; read 0x20 returns 0x11111111.
- Wrap, ADDR_WIDTH = 10: write 0xA5A5A5A5 to 0x1000 -> read 0x0000 returns 0xA5A5A5A5.
